brick_field_renderer: RTL
=========================

Name: brick_field_renderer

Overview:
- Parametrised, pipelined pixel compositor for the breakout game; replaces per-brick hard-coded region decode with index arithmetic over a BRICK_ROWS x BRICK_COLS field.
- Sits between vga_driver (pixel coordinates, syncs) and the VGA pins.
- Adds a frame-counted flash on the most recently destroyed brick, a blinking win/lose background, and sync signals delayed to match the 2-cycle colour latency.

Parameters:
- BRICK_ROWS, 5, rows in field
- BRICK_COLS, 10, columns in field
- BRICK_W_LOG2, 6, log2 brick width in pixels (64)
- BRICK_H_LOG2, 4, log2 brick height in pixels (16)
- FIELD_Y0, 0, top y of field
- BALL_SIZE, 6, ball edge in pixels
- PADDLE_WIDTH, 64, paddle width
- PADDLE_HEIGHT, 8, paddle height
- FLASH_FRAMES, 8, frames a destroyed brick flashes
- BLINK_FRAMES, 16, frames per win/lose blink half-period

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- active_pixels  in  1  pixel inside visible area
- x_pixel, y_pixel  in  10 each  current pixel coordinate
- hsync_in, vsync_in  in  1 each  active-low syncs from vga_driver
- blank_n_in  in  1  blanking from vga_driver
- brick_state  in  BRICK_ROWS*BRICK_COLS  1 = brick alive; index = row*BRICK_COLS+col
- ball_x, ball_y  in  10 each  ball top-left
- paddle_x, paddle_y  in  10 each  paddle top-left
- win, lose  in  1 each  game status levels
- vga_r, vga_g, vga_b  out  8 each  registered colour
- hsync_out, vsync_out, blank_n_out  out  1 each  syncs delayed 2 cycles
- flash_active  out  1  flash counter nonzero

Behaviour:
- Reset (rst=0, async): colour outputs 0; hsync_out=1; vsync_out=1; blank_n_out=0; flash_active=0; flash counter 0; blink phase 1; previous-state register 0.
- Latency: exactly 2 clk from inputs to vga_* outputs. Syncs and blank go through an identical 2-stage delay.
- Stage 1 registers decode flags:
  - in_field: x < BRICK_COLS<<BRICK_W_LOG2 and FIELD_Y0 <= y < FIELD_Y0+(BRICK_ROWS<<BRICK_H_LOG2).
  - col = x>>BRICK_W_LOG2; row = (y-FIELD_Y0)>>BRICK_H_LOG2.
  - alive = in_field & brick_state[idx]. idx is never evaluated out of range (guarded by in_field).
  - ball and paddle hits use 11-bit sums (pos+size) so there is no 10-bit wrap.
- Stage 2 colour priority, first match wins:
  1. !active_pixels -> 000000
  2. ball -> FFFFFF
  3. paddle -> FFFFFF
  4. alive -> row palette[row mod 5] (FF0000, FF8800, FFFF00, 00FF00, 0088FF)
  5. in flashed brick region and flash_cnt != 0 -> C0C0C0
  6. win and phase=1 -> 00FF00
  7. lose (win=0) and phase=1 -> FF0000
  8. otherwise -> 001040
- Frame tick: one-cycle pulse on vsync_in falling edge (registered edge detect).
- Hit capture:
  - Each cycle, cleared = prev_state & ~brick_state; prev_state <= brick_state.
  - If cleared != 0: latch the lowest set index as flash_idx and load flash_cnt = FLASH_FRAMES. A load beats a same-cycle tick.
  - A new hit during a flash restarts it on the new brick.
  - On tick with flash_cnt > 0: decrement. Saturates at 0.
  - If brick_state[flash_idx] returns to 1 (game reset), flash_cnt <= 0 next cycle.
- Blink:
  - While win|lose, a frame counter counts ticks; at BLINK_FRAMES-1 it wraps to 0 and phase toggles.
  - While !(win|lose), counter = 0 and phase = 1, so the status colour shows immediately when win or lose rises.
- Reset mid-frame: outputs go black/inactive at once. The pipeline refills in 2 cycles after release.

Decomposition:
- Package breakout_pkg holds:
  - palette constants: ROW_COLOR[0:4], BG_COLOR, FLASH_COLOR, WIN_COLOR, LOSE_COLOR, BALL_COLOR
  - SCREEN_WIDTH / SCREEN_HEIGHT defaults
  - a clog2-based index-width function
- One sub-module: brick_hit_tracker. It covers the previous-state register, lowest-set-bit priority encoder, flash_idx/flash_cnt and frame-tick input, and outputs flash_idx and flash_active.

Test Plan:
- Reset with all bricks alive; release; drive x=70, y=20, active_pixels=1 -> 2 cycles later RGB = FF8800 (row 1). hsync_out equals hsync_in delayed 2 cycles.
- Clear brick_state[12] -> flash_active=1. Pixel x=130, y=20 gives C0C0C0 for 8 vsync falls; the 9th frame gives 001040.
- Clear bits 3 and 7 in the same cycle -> flash_idx=3. Set bit 3 back to 1 -> flash_active=0 on the next cycle.
- Ball at (100,100) with paddle overlapping, pixel (102,102) -> FFFFFF. Ball_x=636, pixel x=639 -> ball colour with no wrap; pixel x=2 -> background.
- win=1, lose=1, all bricks 0, pixel (300,300) -> 00FF00 for 16 frames, then 001040 for 16, repeating. Dropping win -> FF0000 at once.
- Assert rst mid-line -> RGB=0, hsync_out=vsync_out=1, blank_n_out=0 in the same cycle. Valid colour returns 2 cycles after release.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared colours, screen defaults and pipeline record types for the breakout
// video path.
package breakout_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

  localparam int NUM_PALETTE = 5;
  localparam logic [23:0] ROW_COLOR [0:NUM_PALETTE-1] = '{
    24'hFF0000, 24'hFF8800, 24'hFFFF00, 24'h00FF00, 24'h0088FF
  };
  localparam logic [23:0] BG_COLOR     = 24'h001040;
  localparam logic [23:0] FLASH_COLOR  = 24'hC0C0C0;
  localparam logic [23:0] WIN_COLOR    = 24'h00FF00;
  localparam logic [23:0] LOSE_COLOR   = 24'hFF0000;
  localparam logic [23:0] BALL_COLOR   = 24'hFFFFFF;
  localparam logic [23:0] PADDLE_COLOR = 24'hFFFFFF;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

  // Per-pixel decode carried from stage 1 into the colour mux.
  typedef struct packed {
    logic       active;
    logic       alive;
    logic       flash_region;
    logic       ball;
    logic       paddle;
    logic [2:0] row_mod;
  } pixel_flags_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/brick_hit_tracker.sv
// Detects destroyed bricks, remembers the lowest newly cleared index and runs
// a frame-counted flash timer for it.
module brick_hit_tracker
  import breakout_pkg::*;
#(
  parameter int N_BRICKS     = 50,
  parameter int FLASH_FRAMES = 8,
  parameter int IDX_W        = idx_width(N_BRICKS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_BRICKS-1:0] brick_state_i,
  input  logic                tick_i,
  output logic [IDX_W-1:0]    flash_idx_o,
  output logic                flash_active_o
);

  localparam int CNT_W = idx_width(FLASH_FRAMES + 1);

  logic [N_BRICKS-1:0] prev_q;
  logic [N_BRICKS-1:0] cleared;
  logic [IDX_W-1:0]    hit_idx;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign cleared = prev_q & ~brick_state_i;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    hit_idx = '0;
    for (int i = N_BRICKS - 1; i >= 0; i--) begin
      if (cleared[i]) hit_idx = IDX_W'(i);
    end
  end

  // A fresh hit wins over a brick coming back, which wins over a frame tick.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (|cleared) begin
      idx_d = hit_idx;
      cnt_d = CNT_W'(FLASH_FRAMES);
    end else if (brick_state_i[idx_q]) begin
      cnt_d = '0;
    end else if (tick_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= brick_state_i;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flash_idx_o    = idx_q;
  assign flash_active_o = (cnt_q != '0);

endmodule

// File: rtl/brick_field_renderer.sv
// Two-stage pixel compositor: stage 1 decodes geometry, stage 2 picks the
// colour; syncs follow through a matching 2-stage delay.
module brick_field_renderer
  import breakout_pkg::*;
#(
  parameter int BRICK_ROWS    = 5,
  parameter int BRICK_COLS    = 10,
  parameter int BRICK_W_LOG2  = 6,
  parameter int BRICK_H_LOG2  = 4,
  parameter int FIELD_Y0      = 0,
  parameter int BALL_SIZE     = 6,
  parameter int PADDLE_WIDTH  = 64,
  parameter int PADDLE_HEIGHT = 8,
  parameter int FLASH_FRAMES  = 8,
  parameter int BLINK_FRAMES  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             active_pixels_i,
  input  logic [9:0]                       x_pixel_i,
  input  logic [9:0]                       y_pixel_i,
  input  logic                             hsync_i,
  input  logic                             vsync_i,
  input  logic                             blank_n_i,
  input  logic [BRICK_ROWS*BRICK_COLS-1:0] brick_state_i,
  input  logic [9:0]                       ball_x_i,
  input  logic [9:0]                       ball_y_i,
  input  logic [9:0]                       paddle_x_i,
  input  logic [9:0]                       paddle_y_i,
  input  logic                             win_i,
  input  logic                             lose_i,
  output logic [7:0]                       vga_r_o,
  output logic [7:0]                       vga_g_o,
  output logic [7:0]                       vga_b_o,
  output logic                             hsync_o,
  output logic                             vsync_o,
  output logic                             blank_n_o,
  output logic                             flash_active_o
);

  localparam int N_BRICKS = BRICK_ROWS * BRICK_COLS;
  localparam int IDX_W    = idx_width(N_BRICKS);
  localparam int BLINK_W  = idx_width(BLINK_FRAMES);
  localparam logic [10:0] FIELD_X_END = 11'(BRICK_COLS << BRICK_W_LOG2);
  localparam logic [10:0] FIELD_Y_BEG = 11'(FIELD_Y0);
  localparam logic [10:0] FIELD_Y_END = 11'(FIELD_Y0 + (BRICK_ROWS << BRICK_H_LOG2));

  logic [IDX_W-1:0] flash_idx;
  logic             flash_active;
  logic             vs_prev_q, tick_q;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic             phase_q, phase_d;

  brick_hit_tracker #(
    .N_BRICKS    (N_BRICKS),
    .FLASH_FRAMES(FLASH_FRAMES),
    .IDX_W       (IDX_W)
  ) u_tracker (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .brick_state_i (brick_state_i),
    .tick_i        (tick_q),
    .flash_idx_o   (flash_idx),
    .flash_active_o(flash_active)
  );

  logic [10:0]      x_ext, y_ext, y_rel;
  logic             in_field;
  int               col, row;
  logic [IDX_W-1:0] idx;
  pixel_flags_t     flags_d, flags_q;
  sync_t            sync1_q, sync2_q;
  logic [23:0]      rgb_d, rgb_q;

  // Sums are 11 bits wide so objects near the right/bottom edge never wrap.
  always_comb begin
    x_ext    = {1'b0, x_pixel_i};
    y_ext    = {1'b0, y_pixel_i};
    y_rel    = y_ext - FIELD_Y_BEG;
    in_field = (x_ext < FIELD_X_END) && (y_ext >= FIELD_Y_BEG) && (y_ext < FIELD_Y_END);
    col      = int'(x_ext >> BRICK_W_LOG2);
    row      = int'(y_rel >> BRICK_H_LOG2);
    idx      = IDX_W'(row * BRICK_COLS + col);
    flags_d  = '0;
    flags_d.active = active_pixels_i;
    if (in_field) begin
      flags_d.alive        = brick_state_i[idx];
      flags_d.flash_region = (idx == flash_idx);
      flags_d.row_mod      = 3'(row % NUM_PALETTE);
    end
    flags_d.ball   = (x_ext >= {1'b0, ball_x_i}) && (x_ext < {1'b0, ball_x_i} + 11'(BALL_SIZE)) &&
                     (y_ext >= {1'b0, ball_y_i}) && (y_ext < {1'b0, ball_y_i} + 11'(BALL_SIZE));
    flags_d.paddle = (x_ext >= {1'b0, paddle_x_i}) && (x_ext < {1'b0, paddle_x_i} + 11'(PADDLE_WIDTH)) &&
                     (y_ext >= {1'b0, paddle_y_i}) && (y_ext < {1'b0, paddle_y_i} + 11'(PADDLE_HEIGHT));
  end

  always_comb begin
    rgb_d = BG_COLOR;
    if (!flags_q.active)                         rgb_d = '0;
    else if (flags_q.ball)                       rgb_d = BALL_COLOR;
    else if (flags_q.paddle)                     rgb_d = PADDLE_COLOR;
    else if (flags_q.alive)                      rgb_d = ROW_COLOR[flags_q.row_mod];
    else if (flags_q.flash_region && flash_active) rgb_d = FLASH_COLOR;
    else if (win_i && phase_q)                   rgb_d = WIN_COLOR;
    else if (lose_i && phase_q)                  rgb_d = LOSE_COLOR;
  end

  // Outside win/lose the blink is parked in the visible phase.
  always_comb begin
    blink_d = blink_q;
    phase_d = phase_q;
    if (!(win_i || lose_i)) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (tick_q) begin
      if (blink_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q   <= '0;
      sync1_q   <= SYNC_IDLE;
      sync2_q   <= SYNC_IDLE;
      rgb_q     <= '0;
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
      blink_q   <= '0;
      phase_q   <= 1'b1;
    end else begin
      flags_q   <= flags_d;
      sync1_q   <= '{hsync: hsync_i, vsync: vsync_i, blank_n: blank_n_i};
      sync2_q   <= sync1_q;
      rgb_q     <= rgb_d;
      vs_prev_q <= vsync_i;
      tick_q    <= vs_prev_q & ~vsync_i;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
    end
  end

  assign {vga_r_o, vga_g_o, vga_b_o} = rgb_q;
  assign hsync_o        = sync2_q.hsync;
  assign vsync_o        = sync2_q.vsync;
  assign blank_n_o      = sync2_q.blank_n;
  assign flash_active_o = flash_active;

endmodule
